pixel_stream_loader: RTL

Upstream feeder for the 32x32 panel display driver. Accepts a byte stream (R, G, B per pixel) over a valid/ready handshake, assembles 24-bit pixels and issues single-cycle pixel writes at sequential screen addresses 0..FRAME_PIXELS-1. Optionally holds the start of each frame until the driver's `best_write_time` pulse, so frame loads begin in the longest display phase.

---
 rtl/pixel_stream_loader_if.sv | 21 ++
 rtl/pixel_stream_loader.sv | 68 ++++++
 2 files changed

// File: rtl/pixel_stream_loader_if.sv
// pixel_stream_loader_if: byte stream in, pixel writes out, between feeder and panel driver
interface pixel_stream_loader_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_sof;
  logic in_ready;
  logic best_write_time;
  logic [9:0] write_address;
  logic [23:0] write_color;
  logic write_enable;
  logic frame_done;
  logic sync_error;
  modport master (
    output in_data, in_valid, in_sof, best_write_time,
    input in_ready, write_address, write_color, write_enable, frame_done, sync_error
  );
  modport slave (
    input in_data, in_valid, in_sof, best_write_time,
    output in_ready, write_address, write_color, write_enable, frame_done, sync_error
  );
endinterface

// File: rtl/pixel_stream_loader.sv
// pixel_stream_loader: assembles R,G,B bytes into pixel writes at sequential frame addresses
module pixel_stream_loader #(
  parameter int SYNC_MODE = 1,
  parameter int FRAME_PIXELS = 1024
) (
  input logic clk,
  input logic reset,
  pixel_stream_loader_if.slave bus
);
  typedef enum logic [2:0] {WAIT_SYNC, BYTE_R, BYTE_G, BYTE_B, WRITE} state_t;
  localparam logic [9:0] LAST = 10'(FRAME_PIXELS - 1);
  state_t state, state_n;
  logic [9:0] count;
  logic [7:0] r, g;
  logic sync_q, xfer, sof_x, last, ready_n, we_n, err_n;
  assign xfer = bus.in_valid & bus.in_ready;
  assign sof_x = xfer & bus.in_sof;
  assign last = count == LAST;
  // next state: a sof byte always restarts the pixel as its R byte
  always_comb begin
    state_n = state;
    case (state)
      WAIT_SYNC: state_n = (SYNC_MODE == 0 || sync_q) ? BYTE_R : WAIT_SYNC;
      BYTE_R: state_n = xfer ? BYTE_G : BYTE_R;
      BYTE_G: state_n = sof_x ? BYTE_G : xfer ? BYTE_B : BYTE_G;
      BYTE_B: state_n = sof_x ? BYTE_G : xfer ? WRITE : BYTE_B;
      WRITE: state_n = last ? WAIT_SYNC : BYTE_R;
      default: state_n = WAIT_SYNC;
    endcase
  end
  // next values of the registered outputs; ready follows the next state so it lines up with it
  always_comb begin
    ready_n = state_n inside {BYTE_R, BYTE_G, BYTE_B};
    we_n = xfer & ~bus.in_sof & (state == BYTE_B);
    err_n = sof_x & ~(state == BYTE_R && count == '0);
  end
  // state, datapath and output registers; sync pulse only counts while waiting for it
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_SYNC;
      sync_q <= 1'b0;
      count <= '0;
      r <= '0;
      g <= '0;
      bus.in_ready <= 1'b0;
      bus.write_enable <= 1'b0;
      bus.write_address <= '0;
      bus.write_color <= '0;
      bus.frame_done <= 1'b0;
      bus.sync_error <= 1'b0;
    end else begin
      state <= state_n;
      sync_q <= bus.best_write_time & (state == WAIT_SYNC);
      bus.in_ready <= ready_n;
      bus.write_enable <= we_n;
      bus.frame_done <= we_n & last;
      bus.sync_error <= err_n;
      if (we_n) begin
        bus.write_address <= count;
        bus.write_color <= {bus.in_data, g, r};
      end
      if (xfer && (bus.in_sof || state == BYTE_R)) r <= bus.in_data;
      if (xfer && !bus.in_sof && state == BYTE_G) g <= bus.in_data;
      if (sof_x) count <= '0;
      else if (state == WRITE) count <= last ? '0 : count + 10'd1;
    end
  end
endmodule
